// File: rtl/frame_buffer_writer_pkg.sv
// Shared video package: raster geometry, frame memory address width,
// pixel type and the writer state encoding. The scan-out controller
// imports the same constants so both sides agree on the frame layout.
package frame_buffer_writer_pkg;

  localparam int unsigned H_ACTIVE     = 640;
  localparam int unsigned V_ACTIVE     = 480;
  localparam int unsigned FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
  localparam int unsigned ADDR_W       = 19;
  localparam int unsigned DATA_W       = 24;

  typedef logic [DATA_W-1:0] pixel_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } fbw_state_t;

endpackage

// File: rtl/frame_buffer_writer_if.sv
// Pixel stream handshake bundle (valid/ready plus data and start-of-frame).
//   valid : beat valid            (master -> slave)
//   data  : 8:8:8 RGB pixel       (master -> slave)
//   sof   : beat is pixel (0,0)   (master -> slave)
//   ready : sink accepts the beat (slave -> master)
interface frame_buffer_writer_if;
  import frame_buffer_writer_pkg::*;

  logic   valid;
  logic   ready;
  logic   sof;
  pixel_t data;

  modport master (output valid, output data, output sof, input ready);
  modport slave  (input valid, input data, input sof, output ready);

endinterface

// File: rtl/frame_buffer_writer.sv
// Frame buffer writer: takes a raster-ordered RGB pixel stream and writes it
// linearly into the single-port frame memory shared with scan-out.
// Ports:
//   clk, rst_n        : system clock (also clocks the frame memory), async
//                       active-low reset
//   s                 : pixel stream slave (valid/ready/data/sof)
//   mem_grant         : write port available this cycle
//   mem_addr/mem_data : registered write address / data
//   mem_wren          : registered write strobe, one write per high cycle
//   frame_done        : pulse with the write of the last pixel of a frame
//   sof_err           : pulse with the write of an s_sof beat that arrived mid-frame
//   busy              : a frame is in progress
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for an s_sof beat; other beats are accepted and dropped
// WRITE | writing beats at pix_cnt; leaves after the last pixel of a frame
module frame_buffer_writer
  import frame_buffer_writer_pkg::*;
#(
  // Pixels per frame; overridable so reduced geometries can be exercised.
  parameter int unsigned FRAME_PIX = FRAME_PIXELS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  frame_buffer_writer_if.slave s,
  input  logic                 mem_grant,
  output fb_addr_t             mem_addr,
  output pixel_t               mem_data,
  output logic                 mem_wren,
  output logic                 frame_done,
  output logic                 sof_err,
  output logic                 busy
);

  localparam fb_addr_t LAST_PIX = fb_addr_t'(FRAME_PIX - 1);

  fbw_state_t state;
  fb_addr_t   pix_cnt;
  logic       accept;

  // The arbiter drops grant a cycle ahead, so ready can follow it directly.
  assign s.ready = mem_grant;
  assign accept  = s.valid && mem_grant;
  assign busy    = (state == WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pix_cnt    <= '0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wren   <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      mem_wren   <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
      if (accept) begin
        if (s.sof) begin
          // s_sof always restarts at address 0, even on what would have
          // been the last pixel; the abandoned frame gets no frame_done.
          mem_wren <= 1'b1;
          mem_addr <= '0;
          mem_data <= s.data;
          pix_cnt  <= fb_addr_t'(1);
          sof_err  <= (state == WRITE);
          state    <= WRITE;
        end else if (state == WRITE) begin
          mem_wren <= 1'b1;
          mem_addr <= pix_cnt;
          mem_data <= s.data;
          if (pix_cnt == LAST_PIX) begin
            frame_done <= 1'b1;
            pix_cnt    <= '0;
            state      <= IDLE;
          end else begin
            pix_cnt <= pix_cnt + fb_addr_t'(1);
          end
        end
      end
    end
  end

endmodule
